// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial data qualifier, pattern load,
// overlap mode select and the detector's status outputs.
// master = the side driving the serial stream, slave = the detector.
interface seq_detect_param_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             x;
   logic             pat_load;
   logic [PAT_W-1:0] pattern;
   logic             overlap;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             armed;

   modport master (
      output en,
      output x,
      output pat_load,
      output pattern,
      output overlap,
      input  match,
      input  match_cnt,
      input  armed
   );

   modport slave (
      input  en,
      input  x,
      input  pat_load,
      input  pattern,
      input  overlap,
      output match,
      output match_cnt,
      output armed
   );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: parameterised serial sequence detector.
// A PAT_W-bit target pattern is captured on pat_load; the serial bit x is
// consumed on en cycles and shifted into a history register. A match is
// flagged as a registered one-cycle pulse once PAT_W bits have been
// consumed since the last restart and the history equals the pattern.
// overlap=1 keeps the history after a match, overlap=0 restarts filling.
// Optional feature: define SEQ_DETECT_PARAM_CNT_EN to build the saturating
// match counter; without it match_cnt is tied to zero and has no flops.
module seq_detect_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   seq_detect_param_if.slave bus
);

   // Fill counter must be able to hold the value PAT_W itself.
   localparam int                FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
   localparam logic [PAT_W-1:0]  PAT_ZERO  = {PAT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FILL  = 2'b01,
      ST_ARMED = 2'b10
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [PAT_W-1:0]  pat_r;
   logic [PAT_W-1:0]  pat_nxt_s;
   logic [PAT_W-1:0]  hist_r;
   logic [PAT_W-1:0]  hist_nxt_s;
   logic [PAT_W-1:0]  hist_shift_s;
   logic [FILL_W-1:0] fill_r;
   logic [FILL_W-1:0] fill_nxt_s;
   logic [FILL_W-1:0] fill_inc_s;
   logic              full_s;
   logic              hit_s;
   logic              match_r;
   logic              match_nxt_s;
   logic              armed_r;

   // New bit enters at bit 0; the oldest bit ends up at PAT_W-1, which lines
   // up with the pattern convention (first bit received is the MSB).
   function automatic logic [PAT_W-1:0] shift_in(input logic [PAT_W-1:0] h,
                                                 input logic             b);
      return {h[PAT_W-2:0], b};
   endfunction

   // Fill count saturates at PAT_W so overlapping mode can stay full forever.
   function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
      logic [FILL_W-1:0] r;
      if (f >= FILL_FULL) begin
         r = FILL_FULL;
      end else begin
         r = f + FILL_W'(1);
      end
      return r;
   endfunction

   // Candidate history/fill if the current bit were consumed, and match test.
   always_comb begin
      hist_shift_s = shift_in(hist_r, bus.x);
      fill_inc_s   = fill_sat_inc(fill_r);
      full_s       = (fill_inc_s == FILL_FULL);
      hit_s        = full_s && (hist_shift_s == pat_r);
   end

   // Next-state and next-output logic; pat_load outranks any consumed bit.
   always_comb begin
      state_nxt_s = state_r;
      pat_nxt_s   = pat_r;
      hist_nxt_s  = hist_r;
      fill_nxt_s  = fill_r;
      match_nxt_s = 1'b0;

      if (bus.pat_load) begin
         // Restart with the new pattern; any bit offered this cycle is dropped.
         state_nxt_s = ST_FILL;
         pat_nxt_s   = bus.pattern;
         hist_nxt_s  = PAT_ZERO;
         fill_nxt_s  = FILL_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // No pattern yet: serial input is ignored.
               state_nxt_s = ST_IDLE;
            end
            ST_FILL, ST_ARMED: begin
               if (bus.en) begin
                  hist_nxt_s = hist_shift_s;
                  if (hit_s) begin
                     match_nxt_s = 1'b1;
                     if (bus.overlap) begin
                        // Keep the window full so a suffix can start the next hit.
                        fill_nxt_s  = fill_inc_s;
                        state_nxt_s = ST_ARMED;
                     end else begin
                        // Demand PAT_W fresh bits before the next hit.
                        fill_nxt_s  = FILL_ZERO;
                        state_nxt_s = ST_FILL;
                     end
                  end else begin
                     fill_nxt_s = fill_inc_s;
                     if (full_s) begin
                        state_nxt_s = ST_ARMED;
                     end else begin
                        state_nxt_s = ST_FILL;
                     end
                  end
               end else begin
                  // Idle bus cycle: everything holds, no pulse.
                  state_nxt_s = state_r;
               end
            end
            default: begin
               // Unreachable encoding: fall back to the safe unloaded state.
               state_nxt_s = ST_IDLE;
               pat_nxt_s   = PAT_ZERO;
               hist_nxt_s  = PAT_ZERO;
               fill_nxt_s  = FILL_ZERO;
            end
         endcase
      end
   end

   // State, history and registered outputs; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         pat_r   <= PAT_ZERO;
         hist_r  <= PAT_ZERO;
         fill_r  <= FILL_ZERO;
         match_r <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pat_r   <= pat_nxt_s;
         hist_r  <= hist_nxt_s;
         fill_r  <= fill_nxt_s;
         match_r <= match_nxt_s;
         armed_r <= (state_nxt_s == ST_ARMED);
      end
   end

   assign bus.match = match_r;
   assign bus.armed = armed_r;

`ifdef SEQ_DETECT_PARAM_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] cnt_r;

   // Saturating match counter, cleared by reset or a new pattern load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= CNT_ZERO;
      end else if (bus.pat_load) begin
         cnt_r <= CNT_ZERO;
      end else if (match_nxt_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.match_cnt = cnt_r;
`else
   assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule
